// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus router.
//   state_t            : router FSM state encoding (IDLE, BUSY, ERR)
//   CAUSE_*            : err_cause codes reported with a captured error
//   DEFAULT_ERR_RDATA  : read data returned on an error response
//   idx_width()        : width of a slave index for a given slave count
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ERR  = 2'd2
   } state_t;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_DECODE  = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

   // A single slave still needs a 1-bit index so the vectors stay legal.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_bus_addr_dec.sv
// Combinational address decoder: compares the address against every slave
// window (addr & mask == base) and reports the lowest matching slave.
//   addr : request address
//   hit  : at least one slave window matches
//   idx  : index of the lowest matching slave (0 when no hit)
module mem_bus_addr_dec
   import mem_bus_pkg::*;
#(
   parameter int unsigned              NUM_SLAVES = 4,
   parameter logic [32*NUM_SLAVES-1:0] SLV_BASE   = {32'h0040_0000, 32'h0020_0000,
                                                     32'h0010_0000, 32'h0000_0000},
   parameter logic [32*NUM_SLAVES-1:0] SLV_MASK   = {32'hFFC0_0000, 32'hFFE0_0000,
                                                     32'hFFF0_0000, 32'hFFF0_0000},
   localparam int unsigned             IDX_W      = idx_width(NUM_SLAVES)
) (
   input  logic [31:0]      addr,
   output logic             hit,
   output logic [IDX_W-1:0] idx
);

   // Scan from the top down so the lowest matching index is written last.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
            hit = 1'b1;
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/mem_bus_router.sv
// Routes a single-master valid/ready memory bus onto NUM_SLAVES slaves.
// Decodes the address in IDLE, forwards the request to the selected slave in
// BUSY, and answers undecoded or timed-out accesses with a one-cycle ERR
// response while capturing the failing address and cause.
//   clk, resetn                      : clock, synchronous active-low reset
//   mem_valid/addr/wdata/wstrb       : master request (wstrb == 0 is a read)
//   mem_ready, mem_rdata             : master response
//   s_valid, s_addr, s_wdata, s_wstrb: slave request (one-hot valid)
//   s_ready, s_rdata                 : slave responses, slave 0 in the LSBs
//   err_irq, err_clr                 : sticky error flag and its clear
//   err_addr, err_cause              : address and cause of the last error
module mem_bus_router
   import mem_bus_pkg::*;
#(
   parameter int unsigned              NUM_SLAVES     = 4,
   parameter logic [32*NUM_SLAVES-1:0] SLV_BASE       = {32'h0040_0000, 32'h0020_0000,
                                                         32'h0010_0000, 32'h0000_0000},
   parameter logic [32*NUM_SLAVES-1:0] SLV_MASK       = {32'hFFC0_0000, 32'hFFE0_0000,
                                                         32'hFFF0_0000, 32'hFFF0_0000},
   parameter int unsigned              TIMEOUT_CYCLES = 255,
   parameter logic [31:0]              ERR_RDATA      = DEFAULT_ERR_RDATA
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     mem_valid,
   input  logic [31:0]              mem_addr,
   input  logic [31:0]              mem_wdata,
   input  logic [3:0]               mem_wstrb,
   output logic                     mem_ready,
   output logic [31:0]              mem_rdata,
   output logic [NUM_SLAVES-1:0]    s_valid,
   output logic [31:0]              s_addr,
   output logic [31:0]              s_wdata,
   output logic [3:0]               s_wstrb,
   input  logic [NUM_SLAVES-1:0]    s_ready,
   input  logic [32*NUM_SLAVES-1:0] s_rdata,
   output logic                     err_irq,
   input  logic                     err_clr,
   output logic [31:0]              err_addr,
   output logic [1:0]               err_cause
);

   localparam int unsigned IDX_W    = idx_width(NUM_SLAVES);
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] sel, sel_nxt;
   logic [15:0]      cnt, cnt_nxt;
   logic             err_set;
   logic [1:0]       cause_nxt;
   logic             dec_hit;
   logic [IDX_W-1:0] dec_idx;
   logic [31:0]      rdata_arr [NUM_SLAVES];

   mem_bus_addr_dec #(
      .NUM_SLAVES (NUM_SLAVES),
      .SLV_BASE   (SLV_BASE),
      .SLV_MASK   (SLV_MASK)
   ) u_dec (
      .addr (mem_addr),
      .hit  (dec_hit),
      .idx  (dec_idx)
   );

   // Unpack slave read data so it can be indexed by the latched selection.
   for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_rdata
      assign rdata_arr[k] = s_rdata[32*k +: 32];
   end

   // Request payload is broadcast; only s_valid steers it.
   assign s_addr  = mem_addr;
   assign s_wdata = mem_wdata;
   assign s_wstrb = mem_wstrb;

   // FSM state, slave selection and timeout counter.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         sel   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         sel   <= sel_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Error capture; a new error takes priority over a coincident clear.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         err_irq   <= 1'b0;
         err_addr  <= '0;
         err_cause <= CAUSE_NONE;
      end else if (err_set) begin
         err_irq   <= 1'b1;
         err_addr  <= mem_addr;
         err_cause <= cause_nxt;
      end else if (err_clr) begin
         err_irq   <= 1'b0;
      end
   end

   // Next-state and response logic.
   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      cnt_nxt   = cnt;
      err_set   = 1'b0;
      cause_nxt = CAUSE_NONE;
      s_valid   = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      case (state)
         IDLE: begin
            if (mem_valid) begin
               if (dec_hit) begin
                  sel_nxt   = dec_idx;
                  cnt_nxt   = '0;
                  state_nxt = BUSY;
               end else begin
                  state_nxt = ERR;
                  err_set   = 1'b1;
                  cause_nxt = CAUSE_DECODE;
               end
            end
         end
         BUSY: begin
            s_valid[sel] = mem_valid;
            mem_ready    = s_ready[sel];
            mem_rdata    = rdata_arr[sel];
            // A withdrawn request aborts silently; ready beats the timeout.
            if (!mem_valid || s_ready[sel]) begin
               state_nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ERR;
               err_set   = 1'b1;
               cause_nxt = CAUSE_TIMEOUT;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         ERR: begin
            mem_ready = 1'b1;
            mem_rdata = ERR_RDATA;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_bus_router.sv
// Directed bench for mem_bus_router (4 slaves, default windows, timeout of 4).
module tb_mem_bus_router;

   logic         clk = 1'b0;
   logic         resetn;
   logic         mem_valid;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic [3:0]   mem_wstrb;
   logic         mem_ready;
   logic [31:0]  mem_rdata;
   logic [3:0]   s_valid;
   logic [31:0]  s_addr;
   logic [31:0]  s_wdata;
   logic [3:0]   s_wstrb;
   logic [3:0]   s_ready;
   logic [127:0] s_rdata;
   logic         err_irq;
   logic         err_clr;
   logic [31:0]  err_addr;
   logic [1:0]   err_cause;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_bus_router #(
      .NUM_SLAVES     (4),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .s_valid   (s_valid),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),
      .s_ready   (s_ready),
      .s_rdata   (s_rdata),
      .err_irq   (err_irq),
      .err_clr   (err_clr),
      .err_addr  (err_addr),
      .err_cause (err_cause)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs change here.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      resetn    = 1'b0;
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      s_ready   = '0;
      s_rdata   = '0;
      err_clr   = 1'b0;

      // Reset values
      cyc(); cyc(); #1;
      check("rst_ready",  32'(mem_ready), 32'h0);
      check("rst_rdata",  mem_rdata,      32'h0);
      check("rst_svalid", 32'(s_valid),   32'h0);
      check("rst_irq",    32'(err_irq),   32'h0);
      check("rst_eaddr",  err_addr,       32'h0);
      check("rst_cause",  32'(err_cause), 32'h0);
      resetn = 1'b1;

      // Zero-wait read from slave 0; its early ready in IDLE is ignored
      cyc(); mem_valid = 1'b1; mem_addr = 32'h0000_0010; mem_wstrb = 4'h0;
      s_ready = 4'b0001; s_rdata[31:0] = 32'h1234_5678; #1;
      check("rd_idle_ready",  32'(mem_ready), 32'h0);
      check("rd_idle_svalid", 32'(s_valid),   32'h0);
      check("rd_s_addr",      s_addr,         32'h0000_0010);
      cyc(); #1;
      check("rd_ready",  32'(mem_ready), 32'h1);
      check("rd_rdata",  mem_rdata,      32'h1234_5678);
      check("rd_svalid", 32'(s_valid),   32'h1);
      cyc(); mem_valid = 1'b0; s_ready = '0; #1;
      check("rd_done_ready", 32'(mem_ready), 32'h0);
      check("rd_done_rdata", mem_rdata,      32'h0);

      // Write to slave 2 with three wait cycles; slave 1 ready is a distractor
      cyc(); mem_valid = 1'b1; mem_addr = 32'h0020_0004; mem_wdata = 32'h55AA_00FF;
      mem_wstrb = 4'hF; s_ready = 4'b0010; s_rdata[95:64] = 32'h0BAD_0BAD; #1;
      check("wr_idle_svalid", 32'(s_valid), 32'h0);
      check("wr_s_wdata",     s_wdata,      32'h55AA_00FF);
      check("wr_s_wstrb",     32'(s_wstrb), 32'hF);
      for (int w = 0; w < 3; w++) begin
         cyc(); #1;
         check("wr_wait_svalid", 32'(s_valid),   32'h4);
         check("wr_wait_ready",  32'(mem_ready), 32'h0);
      end
      cyc(); s_ready = 4'b0100; #1;
      check("wr_svalid", 32'(s_valid),   32'h4);
      check("wr_ready",  32'(mem_ready), 32'h1);
      cyc(); mem_valid = 1'b0; s_ready = '0; mem_wstrb = 4'h0; #1;
      check("wr_done_ready",  32'(mem_ready), 32'h0);
      check("wr_done_svalid", 32'(s_valid),   32'h0);
      check("wr_done_irq",    32'(err_irq),   32'h0);

      // Decode error
      cyc(); mem_valid = 1'b1; mem_addr = 32'h8000_0000; #1;
      check("dec_idle_ready", 32'(mem_ready), 32'h0);
      cyc(); #1;
      check("dec_ready",  32'(mem_ready), 32'h1);
      check("dec_rdata",  mem_rdata,      32'hDEAD_BEEF);
      check("dec_svalid", 32'(s_valid),   32'h0);
      check("dec_irq",    32'(err_irq),   32'h1);
      check("dec_eaddr",  err_addr,       32'h8000_0000);
      check("dec_cause",  32'(err_cause), 32'h1);
      cyc(); mem_valid = 1'b0; err_clr = 1'b1; #1;
      check("dec_done_ready", 32'(mem_ready), 32'h0);
      cyc(); err_clr = 1'b0; #1;
      check("clr_irq",        32'(err_irq),   32'h0);
      check("clr_cause_kept", 32'(err_cause), 32'h1);

      // Timeout on slave 1 (never ready; other slaves ready as distractors)
      cyc(); mem_valid = 1'b1; mem_addr = 32'h0010_0000; s_ready = 4'b1101; #1;
      check("to_idle_svalid", 32'(s_valid), 32'h0);
      for (int w = 0; w < 4; w++) begin
         cyc(); #1;
         check("to_busy_svalid", 32'(s_valid),   32'h2);
         check("to_busy_ready",  32'(mem_ready), 32'h0);
      end
      cyc(); #1;
      check("to_ready",  32'(mem_ready), 32'h1);
      check("to_rdata",  mem_rdata,      32'hDEAD_BEEF);
      check("to_svalid", 32'(s_valid),   32'h0);
      check("to_cause",  32'(err_cause), 32'h2);
      check("to_eaddr",  err_addr,       32'h0010_0000);
      check("to_irq",    32'(err_irq),   32'h1);
      cyc(); mem_valid = 1'b0; s_ready = '0; err_clr = 1'b1; #1;
      check("to_done_ready", 32'(mem_ready), 32'h0);
      cyc(); err_clr = 1'b0; #1;
      check("to_clr_irq", 32'(err_irq), 32'h0);

      // Slave 1 ready in the last allowed BUSY cycle wins over the timeout
      cyc(); mem_valid = 1'b1; mem_addr = 32'h0010_0008; s_rdata[63:32] = 32'hCAFE_0001; #1;
      for (int w = 0; w < 3; w++) begin
         cyc(); #1;
         check("late_wait_ready", 32'(mem_ready), 32'h0);
      end
      cyc(); s_ready = 4'b0010; #1;
      check("late_ready", 32'(mem_ready), 32'h1);
      check("late_rdata", mem_rdata,      32'hCAFE_0001);
      cyc(); mem_valid = 1'b0; s_ready = '0; #1;
      check("late_done_ready", 32'(mem_ready), 32'h0);
      check("late_irq",        32'(err_irq),   32'h0);
      check("late_cause_kept", 32'(err_cause), 32'h2);

      // Back-to-back decode errors; clear coinciding with the second one loses
      cyc(); mem_valid = 1'b1; mem_addr = 32'h9000_0000; #1;
      cyc(); #1;
      check("b2b_err1_ready", 32'(mem_ready), 32'h1);
      cyc(); mem_addr = 32'hA000_0000; err_clr = 1'b1; #1;
      check("b2b_idle_ready", 32'(mem_ready), 32'h0);
      check("b2b_idle_irq",   32'(err_irq),   32'h1);
      cyc(); err_clr = 1'b0; #1;
      check("b2b_err2_ready", 32'(mem_ready), 32'h1);
      check("b2b_err2_rdata", mem_rdata,      32'hDEAD_BEEF);
      check("b2b_set_wins",   32'(err_irq),   32'h1);
      check("b2b_eaddr",      err_addr,       32'hA000_0000);
      check("b2b_cause",      32'(err_cause), 32'h1);
      cyc(); mem_valid = 1'b0; err_clr = 1'b1; #1;
      cyc(); err_clr = 1'b0; #1;
      check("b2b_clr_irq", 32'(err_irq), 32'h0);

      // Master withdraws mid-BUSY: silent abort, no error
      cyc(); mem_valid = 1'b1; mem_addr = 32'h0040_0000; #1;
      cyc(); #1;
      check("abt_svalid", 32'(s_valid),   32'h8);
      check("abt_ready",  32'(mem_ready), 32'h0);
      cyc(); mem_valid = 1'b0; #1;
      check("abt_drop_svalid", 32'(s_valid), 32'h0);
      cyc(); s_ready = 4'b1000; #1;
      check("abt_idle_ready", 32'(mem_ready), 32'h0);
      cyc(); #1;
      check("abt_no_err_ready", 32'(mem_ready), 32'h0);
      check("abt_irq",          32'(err_irq),   32'h0);
      s_ready = '0;

      // Reset asserted mid-BUSY, then a normal request
      cyc(); mem_valid = 1'b1; mem_addr = 32'h0000_0020; s_rdata[31:0] = 32'hA5A5_A5A5; #1;
      cyc(); #1;
      check("rstb_svalid", 32'(s_valid), 32'h1);
      resetn = 1'b0;
      cyc(); s_ready = 4'b0001; #1;
      check("rstb_svalid0", 32'(s_valid),   32'h0);
      check("rstb_ready0",  32'(mem_ready), 32'h0);
      check("rstb_eaddr",   err_addr,       32'h0);
      check("rstb_cause",   32'(err_cause), 32'h0);
      check("rstb_irq",     32'(err_irq),   32'h0);
      resetn = 1'b1;
      cyc(); #1;
      check("post_rst_ready", 32'(mem_ready), 32'h1);
      check("post_rst_rdata", mem_rdata,      32'hA5A5_A5A5);
      cyc(); mem_valid = 1'b0; s_ready = '0; #1;
      check("post_rst_done", 32'(mem_ready), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
